// File: rtl/fetch_unit.sv
// fetch_unit: RV32 fetch stage with credit-gated in-order imem requests and a PC/instruction queue.
// Optional: FETCH_MISALIGN_CHECK_EN adds the sticky fetch_misalign flag. Rev 1.0
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC_In,
  input  logic        redirect,
  output logic [31:0] PCF,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        InstrD_valid,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  input  logic        id_ready
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam int               c_AW     = $clog2(QDEPTH);
  localparam logic [c_AW+1:0]  c_QDEPTH = (c_AW+2)'(QDEPTH);

  logic [31:0]   r_pcf;
  logic [31:0]   r_if_pc   [QDEPTH];
  logic [c_AW-1:0] r_if_wp, r_if_rp;
  logic [c_AW:0] r_if_cnt;
  logic [31:0]   r_q_pc    [QDEPTH];
  logic [31:0]   r_q_instr [QDEPTH];
  logic [c_AW-1:0] r_q_wp, r_q_rp;
  logic [c_AW:0] r_q_cnt;
  logic [c_AW:0] r_drop_cnt;

  logic [c_AW+1:0] w_occ;
  logic            w_mis_block;
  logic            w_pc_bad;
  logic            w_issue;
  logic            w_load;
  logic            w_pop;
  logic            w_push;
  logic [c_AW:0]   w_issue_n, w_rsp_n, w_push_n, w_pop_n;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misalign;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else if (w_load && w_pc_bad) begin
      r_misalign <= 1'b1;
    end
  end

  assign fetch_misalign = r_misalign;
  assign w_mis_block    = r_misalign;
  assign w_pc_bad       = (PC_In[1:0] != 2'b00);
`else
  assign w_mis_block    = 1'b0;
  assign w_pc_bad       = 1'b0;
`endif

  // Credit covers both in-flight and queued entries, so a kept response always has a slot.
  assign w_occ          = {1'b0, r_if_cnt} + {1'b0, r_q_cnt};
  assign imem_req_valid = rst_n && (w_occ < c_QDEPTH) && !redirect && !w_mis_block;
  assign imem_req_addr  = r_pcf;
  assign PCF            = r_pcf;

  assign w_issue = imem_req_valid && imem_req_ready;
  assign w_load  = w_issue || redirect;
  assign w_pop   = InstrD_valid && id_ready;
  assign w_push  = imem_rsp_valid && !redirect && (r_drop_cnt == '0);

  assign w_issue_n = {{c_AW{1'b0}}, w_issue};
  assign w_rsp_n   = {{c_AW{1'b0}}, imem_rsp_valid};
  assign w_push_n  = {{c_AW{1'b0}}, w_push};
  assign w_pop_n   = {{c_AW{1'b0}}, w_pop};

  assign InstrD_valid = (r_q_cnt != '0);
  assign InstrD       = r_q_instr[r_q_rp];
  assign PCD          = r_q_pc[r_q_rp];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pcf      <= RESET_PC;
      r_if_wp    <= '0;
      r_if_rp    <= '0;
      r_if_cnt   <= '0;
      r_q_wp     <= '0;
      r_q_rp     <= '0;
      r_q_cnt    <= '0;
      r_drop_cnt <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_if_pc[i]   <= '0;
        r_q_pc[i]    <= '0;
        r_q_instr[i] <= '0;
      end
    end else begin
      if (w_load && !w_pc_bad) begin
        r_pcf <= PC_In;
      end

      if (w_issue) begin
        r_if_pc[r_if_wp] <= r_pcf;
        r_if_wp          <= r_if_wp + 1'b1;
      end
      if (imem_rsp_valid) begin
        r_if_rp <= r_if_rp + 1'b1;
      end
      r_if_cnt <= r_if_cnt + w_issue_n - w_rsp_n;

      // Everything still outstanding at a redirect belongs to the squashed path.
      if (redirect) begin
        r_drop_cnt <= r_if_cnt - w_rsp_n;
      end else if (imem_rsp_valid && (r_drop_cnt != '0)) begin
        r_drop_cnt <= r_drop_cnt - 1'b1;
      end

      if (w_push) begin
        r_q_pc[r_q_wp]    <= r_if_pc[r_if_rp];
        r_q_instr[r_q_wp] <= imem_rsp_data;
      end
      if (redirect) begin
        r_q_wp  <= '0;
        r_q_rp  <= '0;
        r_q_cnt <= '0;
      end else begin
        if (w_push) r_q_wp <= r_q_wp + 1'b1;
        if (w_pop)  r_q_rp <= r_q_rp + 1'b1;
        r_q_cnt <= r_q_cnt + w_push_n - w_pop_n;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch_unit bench against a queue-based reference model.
`default_nettype none

module tb_fetch_unit;

  localparam int          QD  = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] PC_In = '0;
  logic        redirect = 1'b0;
  logic [31:0] PCF;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        InstrD_valid;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic        id_ready = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PC_In          (PC_In),
    .redirect       (redirect),
    .PCF            (PCF),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .InstrD_valid   (InstrD_valid),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .id_ready       (id_ready)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  // Reference state: in-flight PCs with due cycles, output queue, drop count.
  logic [31:0] m_pcf;
  logic [31:0] m_infl[$];
  int          m_due[$];
  logic [31:0] m_oq_pc[$];
  logic [31:0] m_oq_in[$];
  int          m_drop = 0;
  bit          m_mis = 0;
  bit          m_known = 0;

  bit          s_rst = 0, s_redir = 0, s_rdy = 0, s_idr = 0;
  logic [31:0] s_tgt = '0;
  int          lat = 1;
  int          cyc = 0;
  int          n_pass = 0, n_total = 0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit exp_req_valid();
    return s_rst && ((m_infl.size() + m_oq_pc.size()) < QD) && !s_redir && !m_mis;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic drive_and_check();
    @(negedge clk);
    rst_n          = s_rst;
    redirect       = s_redir;
    PC_In          = s_redir ? s_tgt : m_pcf + 32'd4;
    imem_req_ready = s_rdy;
    id_ready       = s_idr;
    if (s_rst && m_infl.size() > 0 && m_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memfn(m_infl[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    if (m_known) begin
      chk("PCF", PCF, m_pcf);
      chk("req_addr", imem_req_addr, m_pcf);
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req_valid()});
      chk("instr_valid", {31'b0, InstrD_valid}, {31'b0, m_oq_pc.size() > 0});
      if (m_oq_pc.size() > 0) begin
        chk("PCD", PCD, m_oq_pc[0]);
        chk("InstrD", InstrD, m_oq_in[0]);
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("misalign", {31'b0, fetch_misalign}, {31'b0, m_mis});
`endif
    end
  endtask

  task automatic advance();
    bit e, iss, pop, push;
    logic [31:0] ppc;
    e = exp_req_valid();
    @(posedge clk);
    if (!rst_n) begin
      m_pcf = RPC;
      m_infl.delete(); m_due.delete();
      m_oq_pc.delete(); m_oq_in.delete();
      m_drop = 0; m_mis = 0; m_known = 1;
    end else begin
      iss  = e && imem_req_ready;
      pop  = (m_oq_pc.size() > 0) && id_ready;
      push = 0;
      ppc  = '0;
      if (imem_rsp_valid && m_infl.size() > 0) begin
        ppc = m_infl.pop_front();
        void'(m_due.pop_front());
        if (!redirect) begin
          if (m_drop > 0) m_drop--;
          else push = 1;
        end
      end
      if (pop) begin
        void'(m_oq_pc.pop_front());
        void'(m_oq_in.pop_front());
      end
      if (push) begin
        m_oq_pc.push_back(ppc);
        m_oq_in.push_back(imem_rsp_data);
      end
      if (redirect) begin
        m_oq_pc.delete(); m_oq_in.delete();
        m_drop = m_infl.size();
      end
      if (iss) begin
        m_infl.push_back(m_pcf);
        m_due.push_back(cyc + lat);
      end
      if (iss || redirect) begin
`ifdef FETCH_MISALIGN_CHECK_EN
        if (PC_In[1:0] != 2'b00) m_mis = 1;
        else m_pcf = PC_In;
`else
        m_pcf = PC_In;
`endif
      end
    end
    cyc++;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      drive_and_check();
      advance();
    end
  endtask

  initial begin
    bit found;
    // Reset state
    s_rst = 0; s_rdy = 1; s_idr = 1; lat = 1;
    step(2);
    drive_and_check();
    chk("rst_pcf", PCF, 32'h0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_instr_valid", {31'b0, InstrD_valid}, 32'h0);
    chk("rst_pcd", PCD, 32'h0);
    chk("rst_instr", InstrD, 32'h0);
    advance();

    // Steady stream with a 1-cycle memory
    s_rst = 1;
    drive_and_check();
    chk("s0_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("s0_addr", imem_req_addr, 32'h0);
    advance();
    drive_and_check();
    chk("s1_addr", imem_req_addr, 32'h4);
    chk("s1_instr_valid", {31'b0, InstrD_valid}, 32'h0);
    advance();
    drive_and_check();
    chk("s2_instr_valid", {31'b0, InstrD_valid}, 32'h1);
    chk("s2_pcd", PCD, 32'h0);
    chk("s2_instr", InstrD, memfn(32'h0));
    advance();
    step(10);

    // Backpressure
    s_rst = 0; step(1);
    s_rst = 1; s_idr = 0;
    step(4);
    drive_and_check();
    chk("bp_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("bp_pcf", PCF, 32'h8);
    chk("bp_pcd", PCD, 32'h0);
    chk("bp_instr_valid", {31'b0, InstrD_valid}, 32'h1);
    advance();
    s_idr = 1;
    step(8);

    // Redirect with two requests in flight on a 3-cycle memory
    s_rst = 0; step(1);
    s_rst = 1; lat = 3;
    step(2);
    s_redir = 1; s_tgt = 32'h100;
    step(1);
    s_redir = 0;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      drive_and_check();
      if (!found && InstrD_valid) begin
        found = 1;
        chk("redir_first_pcd", PCD, 32'h100);
      end
      advance();
    end
    chk("redir_delivered", {31'b0, found}, 32'h1);

    // Reset mid-fetch with a full queue
    lat = 1; s_idr = 0;
    step(5);
    s_rst = 0; step(1);
    drive_and_check();
    chk("midrst_instr_valid", {31'b0, InstrD_valid}, 32'h0);
    chk("midrst_pcf", PCF, RPC);
    advance();
    s_rst = 1; s_idr = 1;
    step(4);

`ifdef FETCH_MISALIGN_CHECK_EN
    s_rst = 0; step(1);
    s_rst = 1; s_redir = 1; s_tgt = 32'h102;
    step(1);
    s_redir = 0;
    drive_and_check();
    chk("mis_flag", {31'b0, fetch_misalign}, 32'h1);
    chk("mis_pcf", PCF, 32'h0);
    chk("mis_req_valid", {31'b0, imem_req_valid}, 32'h0);
    advance();
    step(5);
`endif

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      s_rst   = ($urandom % 200) != 0;
      s_redir = ($urandom % 20) == 0;
      s_tgt   = $urandom & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (($urandom % 8) == 0) s_tgt[1:0] = 2'($urandom_range(1, 3));
`endif
      s_rdy = ($urandom % 4) != 0;
      s_idr = ($urandom % 3) != 0;
      lat   = $urandom_range(1, 4);
      step(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
